// File: rtl/regf_pkg.sv
// Register-file constants shared by the write-back arbiter, the register file and decode.
package regf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_NUM    = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr, wrapping, wins a one-hot grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  int unsigned      k;
  logic [PTR_W-1:0] ki;
  logic             found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    ki    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      k = 32'(ptr) + off;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      ki = k[PTR_W-1:0];
      if (!found && req[ki]) begin
        found   = 1'b1;
        gnt[ki] = 1'b1;
        idx     = ki;
      end
    end
  end

endmodule

// File: rtl/regf_wb_arbiter.sv
// Shares the register file write port among write-back requesters and tracks pending
// destination registers for read-after-write hazard detection.
module regf_wb_arbiter
  import regf_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          WE3,
  output logic [REG_ADDR_W-1:0]         A3,
  output logic [DATA_W-1:0]             WD3,
  input  logic                          resv_valid,
  input  logic [REG_ADDR_W-1:0]         resv_addr,
  input  logic [REG_ADDR_W-1:0]         chk_addr1,
  input  logic [REG_ADDR_W-1:0]         chk_addr2,
  output logic                          chk_busy1,
  output logic                          chk_busy2,
  output logic                          resv_err
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]     data_q, data_d;
  logic [REG_NUM-1:0]    busy_q, busy_d;
  logic                  err_q, err_d;

  logic [NUM_REQ-1:0]    gnt;
  logic [PTR_W-1:0]      win;
  logic                  xfer;
  logic [REG_ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_data;
  logic                  resv_set;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win)
  );

  // Grants are held off while reset is asserted so nothing is consumed and then dropped.
  assign req_ready = rst ? gnt : '0;
  assign xfer      = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == PTR_W'(i)) begin
        sel_addr = req_addr[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    we_d   = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (xfer) begin
      we_d   = (sel_addr != ZERO_REG);
      addr_d = sel_addr;
      data_d = sel_data;
      ptr_d  = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  assign resv_set = resv_valid && (resv_addr != ZERO_REG);

  // A reservation of the register being written back this edge is legal: the old value retires.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[addr_q] = 1'b0;
    if (resv_set) busy_d[resv_addr] = 1'b1;
    err_d = err_q;
    if (resv_set && busy_q[resv_addr] && !(we_q && (addr_q == resv_addr))) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q  <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign WE3       = we_q;
  assign A3        = addr_q;
  assign WD3       = data_q;
  assign chk_busy1 = (chk_addr1 != ZERO_REG) && busy_q[chk_addr1];
  assign chk_busy2 = (chk_addr2 != ZERO_REG) && busy_q[chk_addr2];
  assign resv_err  = err_q;

endmodule

// File: tb/tb_regf_wb_arbiter.sv
// Directed table-driven bench for regf_wb_arbiter with NUM_REQ=2.
module tb_regf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [9:0]  req_addr = '0;
  logic [63:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        WE3;
  logic [4:0]  A3;
  logic [31:0] WD3;
  logic        resv_valid = 1'b0;
  logic [4:0]  resv_addr = '0;
  logic [4:0]  chk_addr1 = '0;
  logic [4:0]  chk_addr2 = '0;
  logic        chk_busy1, chk_busy2, resv_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regf_wb_arbiter #(
    .NUM_REQ (2),
    .DATA_W  (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .resv_valid (resv_valid),
    .resv_addr  (resv_addr),
    .chk_addr1  (chk_addr1),
    .chk_addr2  (chk_addr2),
    .chk_busy1  (chk_busy1),
    .chk_busy2  (chk_busy2),
    .resv_err   (resv_err)
  );

  typedef struct {
    logic [1:0]  rv;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    logic        rs;
    logic [4:0]  ra, c1, c2;
    logic [1:0]  e_rdy;
    logic        e_we;
    logic [4:0]  e_a3;
    logic [31:0] e_wd;
    logic        e_b1, e_b2, e_err;
  } vec_t;

  localparam int NV = 30;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk({tag, " req_ready"}, 32'(req_ready), 32'(v.e_rdy));
    chk({tag, " WE3"},       32'(WE3),       32'(v.e_we));
    chk({tag, " A3"},        32'(A3),        32'(v.e_a3));
    chk({tag, " WD3"},       WD3,            v.e_wd);
    chk({tag, " chk_busy1"}, 32'(chk_busy1), 32'(v.e_b1));
    chk({tag, " chk_busy2"}, 32'(chk_busy2), 32'(v.e_b2));
    chk({tag, " resv_err"},  32'(resv_err),  32'(v.e_err));
  endtask

  initial begin
    int n;
    n = 0;
    //           rv     a0 a1 d0            d1            rs ra c1 c2  rdy   we a3 wd            b1 b2 err
    // reset state, then single request to x5
    vec[n++] = '{2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 5, 7,  2'b00, 0, 0, 32'h0,        0, 0, 0};
    vec[n++] = '{2'b01, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 5, 7,  2'b01, 0, 0, 32'h0,        0, 0, 0};
    vec[n++] = '{2'b00, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 5, 7,  2'b00, 1, 5, 32'hDEADBEEF, 0, 0, 0};
    vec[n++] = '{2'b00, 5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 5, 7,  2'b00, 0, 5, 32'hDEADBEEF, 0, 0, 0};
    // contention, pointer at 1 after the previous grant
    vec[n++] = '{2'b11, 3, 4, 32'h11111111, 32'h22222222, 0, 0, 5, 7,  2'b10, 0, 5, 32'hDEADBEEF, 0, 0, 0};
    vec[n++] = '{2'b11, 3, 4, 32'h11111111, 32'h22222222, 0, 0, 5, 7,  2'b01, 1, 4, 32'h22222222, 0, 0, 0};
    vec[n++] = '{2'b11, 3, 4, 32'h11111111, 32'h22222222, 0, 0, 5, 7,  2'b10, 1, 3, 32'h11111111, 0, 0, 0};
    vec[n++] = '{2'b11, 3, 4, 32'h11111111, 32'h22222222, 0, 0, 5, 7,  2'b01, 1, 4, 32'h22222222, 0, 0, 0};
    vec[n++] = '{2'b00, 3, 4, 32'h11111111, 32'h22222222, 0, 0, 5, 7,  2'b00, 1, 3, 32'h11111111, 0, 0, 0};
    // scoreboard: reserve x7, write x7
    vec[n++] = '{2'b00, 0, 0, 32'h0,        32'h0,        1, 7, 7, 9,  2'b00, 0, 3, 32'h11111111, 0, 0, 0};
    vec[n++] = '{2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 7, 9,  2'b00, 0, 3, 32'h11111111, 1, 0, 0};
    vec[n++] = '{2'b01, 7, 0, 32'h77,       32'h0,        0, 0, 7, 9,  2'b01, 0, 3, 32'h11111111, 1, 0, 0};
    vec[n++] = '{2'b00, 7, 0, 32'h77,       32'h0,        0, 0, 7, 9,  2'b00, 1, 7, 32'h77,       1, 0, 0};
    vec[n++] = '{2'b00, 7, 0, 32'h77,       32'h0,        0, 0, 7, 9,  2'b00, 0, 7, 32'h77,       0, 0, 0};
    // same-cycle set and clear on x9
    vec[n++] = '{2'b00, 0, 0, 32'h0,        32'h0,        1, 9, 7, 9,  2'b00, 0, 7, 32'h77,       0, 0, 0};
    vec[n++] = '{2'b10, 0, 9, 32'h0,        32'h99,       0, 0, 7, 9,  2'b10, 0, 7, 32'h77,       0, 1, 0};
    vec[n++] = '{2'b00, 0, 9, 32'h0,        32'h99,       1, 9, 7, 9,  2'b00, 1, 9, 32'h99,       0, 1, 0};
    vec[n++] = '{2'b00, 0, 9, 32'h0,        32'h99,       0, 0, 7, 9,  2'b00, 0, 9, 32'h99,       0, 1, 0};
    // illegal re-reserve of x7
    vec[n++] = '{2'b00, 0, 0, 32'h0,        32'h0,        1, 7, 7, 9,  2'b00, 0, 9, 32'h99,       0, 1, 0};
    vec[n++] = '{2'b00, 0, 0, 32'h0,        32'h0,        1, 7, 7, 9,  2'b00, 0, 9, 32'h99,       1, 1, 0};
    vec[n++] = '{2'b00, 0, 0, 32'h0,        32'h0,        0, 0, 7, 9,  2'b00, 0, 9, 32'h99,       1, 1, 1};
    // x0 write and x0 reservation
    vec[n++] = '{2'b01, 0, 0, 32'hFFFFFFFF, 32'h0,        0, 0, 7, 9,  2'b01, 0, 9, 32'h99,       1, 1, 1};
    vec[n++] = '{2'b00, 0, 0, 32'hFFFFFFFF, 32'h0,        1, 0, 7, 0,  2'b00, 0, 0, 32'hFFFFFFFF, 1, 0, 1};
    vec[n++] = '{2'b00, 0, 0, 32'hFFFFFFFF, 32'h0,        0, 0, 7, 0,  2'b00, 0, 0, 32'hFFFFFFFF, 1, 0, 1};

    // reset state with a requester already valid: ready must stay low
    req_valid = 2'b11;
    req_addr  = {5'd2, 5'd1};
    chk_addr1 = 5'd5;
    chk_addr2 = 5'd7;
    #12;
    chk("reset req_ready", 32'(req_ready), 32'h0);
    chk("reset WE3", 32'(WE3), 32'h0);
    chk("reset resv_err", 32'(resv_err), 32'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      req_valid  = vec[i].rv;
      req_addr   = {vec[i].a1, vec[i].a0};
      req_data   = {vec[i].d1, vec[i].d0};
      resv_valid = vec[i].rs;
      resv_addr  = vec[i].ra;
      chk_addr1  = vec[i].c1;
      chk_addr2  = vec[i].c2;
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vec[i]);
    end

    // reset mid-write: x7 and x9 are busy and resv_err is set going in
    @(posedge clk);
    #1;
    req_valid  = 2'b01;
    req_addr   = {5'd0, 5'd12};
    req_data   = {32'h0, 32'hABCD1234};
    resv_valid = 1'b0;
    chk_addr1  = 5'd7;
    chk_addr2  = 5'd9;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("midrst WE3 before", 32'(WE3), 32'h1);
    chk("midrst A3 before", 32'(A3), 32'd12);
    req_valid = 2'b10;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst WE3", 32'(WE3), 32'h0);
    chk("midrst A3", 32'(A3), 32'h0);
    chk("midrst WD3", WD3, 32'h0);
    chk("midrst chk_busy1", 32'(chk_busy1), 32'h0);
    chk("midrst chk_busy2", 32'(chk_busy2), 32'h0);
    chk("midrst resv_err", 32'(resv_err), 32'h0);
    chk("midrst req_ready", 32'(req_ready), 32'h0);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;

    // after reset the pointer is back at 0: contention grants requester 0 first
    @(posedge clk);
    #1;
    req_valid = 2'b11;
    req_addr  = {5'd4, 5'd3};
    @(negedge clk);
    chk("post-reset first grant", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("post-reset second grant", 32'(req_ready), 32'h2);
    chk("post-reset WE3", 32'(WE3), 32'h1);
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regf_wb_arbiter.md
# regf_wb_arbiter

Write-back arbiter and scoreboard for the 32 x 32-bit register file. It shares the file's single synchronous write port (WE3/A3/WD3) between NUM_REQ write-back requesters, such as the ALU result path and the load path, using round-robin priority. It also keeps a per-register busy vector so the decode stage can detect read-after-write hazards. It sits between the write-back sources and the register file; the register file's read ports are untouched.

## Interface
- NUM_REQ, 2, number of write-back requesters (2..4)
- DATA_W, 32, register data width
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i holds a write
- req_addr  in  NUM_REQ*5  destination register per requester, packed with requester i at [5i+4:5i]
- req_data  in  NUM_REQ*DATA_W  write data per requester, packed in the same way
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high at the edge
- WE3  out  1  register-file write enable (registered)
- A3  out  5  register-file write address (registered)
- WD3  out  DATA_W  register-file write data (registered)
- resv_valid  in  1  issue stage reserves a destination register this cycle
- resv_addr  in  5  register being reserved
- chk_addr1, chk_addr2  in  5 each  source registers under hazard check
- chk_busy1, chk_busy2  out  1 each  combinational busy status of chk_addr1/chk_addr2
- resv_err  out  1  sticky flag; set when a reservation targets an already-busy register

## Operation
- Reset (rst low, asynchronous) forces:
  - WE3=0, A3=0, WD3=0
  - busy vector all 0 and resv_err=0
  - round-robin pointer to requester 0
  - req_ready is combinational and therefore all 0 while rst is low.
- Arbitration:
  - Combinational, over req_valid.
  - Search starts at the pointer and wraps modulo NUM_REQ; the first valid requester gets req_ready.
  - At most one ready bit is high per cycle.
  - With no valid requester, req_ready=0.
- On an accepted transfer:
  - The output stage loads A3 and WD3.
  - WE3 is set to 1 unless the address is 0; a write to x0 is accepted and consumed but never reaches the file.
  - The pointer moves to the winner+1 (mod NUM_REQ).
- With no transfer, WE3 returns to 0, A3/WD3 hold their values, and the pointer holds.
- Requesters must hold valid, addr and data stable until accepted. The output stage always drains each cycle, so there is no backpressure from the file side.
- Busy vector:
  - resv_valid sets busy[resv_addr]; resv_addr=0 is ignored.
  - WE3=1 clears busy[A3] at the same edge on which the file writes.
  - If a set and a clear hit the same register in one cycle, the set wins.
- resv_err is set when resv_valid is high and busy[resv_addr] is already 1 (a write-after-write to a pending register is illegal). It stays set until reset.
- chk_busyN = busy[chk_addrN], with address 0 always reporting 0. There is no bypass from the output stage.

## Timing
- Transfer accepted at edge N: WE3/A3/WD3 are valid throughout cycle N+1, the file is written at edge N+1, and the busy bit is clear from cycle N+2.
- A reservation made at edge N shows chk_busy=1 from cycle N+1.
- Throughput is one write per cycle. Under continuous contention each requester is served at least once every NUM_REQ cycles.
- Reset asserted mid-operation drops any write pending in the output stage; the file's own reset clears its contents anyway.

## Structure
- Shared package regf_pkg holds REG_ADDR_W=5, REG_NUM=32, ZERO_REG=5'd0. The register file and decode stage import the same constants.
- One sub-module, rr_arbiter, parameterised by NUM_REQ:
  - inputs: req vector and pointer
  - outputs: one-hot grant and encoded winner index
- The output stage, pointer, busy vector and resv_err live in regf_wb_arbiter.

## Test plan
- Reset mid-write: with WE3=1, pull rst low mid-cycle -> WE3=0, A3=0, WD3=0, all chk_busy=0, and resv_err=0 immediately.
- Single request: requester 0 writes addr 5, data 0xDEADBEEF -> req_ready[0] in the same cycle, then WE3=1, A3=5, WD3=0xDEADBEEF for exactly one cycle.
- Contention: both requesters valid continuously (addrs 3 and 4) -> grants alternate 0,1,0,1 and WE3 stays high every cycle.
- Scoreboard: reserve x7, then write x7 -> chk_busy1 (chk_addr1=7) reads 0,1,...,1 and drops in the second cycle after acceptance. An illegal second reserve of x7 sets resv_err.
- x0 handling: write to x0 with data 0xFFFFFFFF -> accepted, WE3 stays 0. Reserving x0 never makes chk_busy high.
- Same-cycle set and clear: re-reserve x9 in the cycle WE3=1 with A3=9 -> busy[9] remains 1 and resv_err is unchanged.
